interp_seq_ctrl: RTL and testbench

- Sequencer for the polyphase interpolation datapath.
- Accepts one input sample per frame via a valid/ready handshake and writes it into a 2^ADDR_W-entry circular history RAM.
- Then walks L phases x K taps, driving addr_data (history read address) and addr_factor (coefficient ROM address) plus MAC control strobes to the compute unit.
- Replaces the free-running address generator; clears the history RAM after reset.

---
 rtl/interp_seq_ctrl.sv | 152 +++++++++++++++
 tb/tb_interp_seq_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/interp_seq_ctrl.sv
// Polyphase interpolation sequencer: clears the history RAM after reset, then
// per input sample writes it into the circular history and walks L phases x K
// taps, issuing history/coefficient addresses and MAC strobes.
module interp_seq_ctrl #(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 8,
   parameter int COEF_AW = 8,
   parameter int L       = 4,
   parameter int K       = 25,
   parameter int PH_W    = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  in_data,
   output logic               hist_we,
   output logic [ADDR_W-1:0]  hist_waddr,
   output logic [DATA_W-1:0]  hist_wdata,
   output logic [ADDR_W-1:0]  addr_data,
   output logic [COEF_AW-1:0] addr_factor,
   output logic               mac_en,
   output logic               tap_first,
   output logic               tap_last,
   output logic [PH_W-1:0]    phase_idx,
   output logic               frame_done,
   output logic               init_done
);

   localparam int                 KW     = (K > 1) ? $clog2(K) : 1;
   localparam logic [KW-1:0]      K_LAST = KW'(K - 1);
   localparam logic [PH_W-1:0]    P_LAST = PH_W'(L - 1);
   localparam logic [COEF_AW-1:0] L_STEP = COEF_AW'(L);

   typedef enum logic [1:0] {S_CLR, S_IDLE, S_WRITE, S_MAC} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W:0]   clr_cnt;   // MSB set once every address has been cleared
   logic [ADDR_W-1:0] wr_ptr;    // slot holding the newest sample
   logic [KW-1:0]     k;         // tap currently on the outputs
   logic [PH_W-1:0]   p;         // phase currently on the outputs
   logic [KW-1:0]     k_inc;
   logic              last_tap;
   logic              clr_end;

   assign k_inc    = k + 1'b1;
   assign last_tap = (k == K_LAST) && (p == P_LAST);
   assign clr_end  = clr_cnt[ADDR_W];
   assign in_ready = (state == S_IDLE) & ~rst;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_CLR;
      else     state <= state_nxt;
   end

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         S_CLR:   if (clr_end)  state_nxt = S_IDLE;
         S_IDLE:  if (in_valid) state_nxt = S_WRITE;
         S_WRITE: state_nxt = S_MAC;
         S_MAC:   if (last_tap) state_nxt = S_IDLE;
         default: state_nxt = S_CLR;
      endcase
   end

   // Registered outputs: each edge loads what the cycle being entered shows
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         clr_cnt     <= '0;
         k           <= '0;
         p           <= '0;
         hist_we     <= 1'b0;
         hist_waddr  <= '0;
         hist_wdata  <= '0;
         addr_data   <= '0;
         addr_factor <= '0;
         phase_idx   <= '0;
         mac_en      <= 1'b0;
         tap_first   <= 1'b0;
         tap_last    <= 1'b0;
         frame_done  <= 1'b0;
         init_done   <= 1'b0;
      end else begin
         hist_we    <= 1'b0;
         mac_en     <= 1'b0;
         tap_first  <= 1'b0;
         tap_last   <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            S_CLR: begin
               if (clr_end) begin
                  init_done <= 1'b1;
               end else begin
                  hist_we    <= 1'b1;
                  hist_waddr <= clr_cnt[ADDR_W-1:0];
                  hist_wdata <= '0;
                  clr_cnt    <= clr_cnt + 1'b1;
               end
            end
            S_IDLE: begin
               if (in_valid) begin
                  hist_we    <= 1'b1;
                  hist_waddr <= wr_ptr;
                  hist_wdata <= in_data;
               end
            end
            S_WRITE: begin
               // first tap of phase 0 reads the sample just written
               k           <= '0;
               p           <= '0;
               mac_en      <= 1'b1;
               tap_first   <= 1'b1;
               tap_last    <= (K == 1);
               addr_data   <= wr_ptr;
               addr_factor <= '0;
               phase_idx   <= '0;
            end
            S_MAC: begin
               if (last_tap) begin
                  frame_done <= 1'b1;
                  wr_ptr     <= wr_ptr + 1'b1;
                  k          <= '0;
                  p          <= '0;
               end else if (k == K_LAST) begin
                  // next phase restarts at the newest sample, coef index = phase
                  k           <= '0;
                  p           <= p + 1'b1;
                  mac_en      <= 1'b1;
                  tap_first   <= 1'b1;
                  tap_last    <= (K == 1);
                  addr_data   <= wr_ptr;
                  addr_factor <= COEF_AW'(p) + 1'b1;
                  phase_idx   <= p + 1'b1;
               end else begin
                  // step one sample older, coefficients stride by L
                  k           <= k_inc;
                  mac_en      <= 1'b1;
                  tap_last    <= (k_inc == K_LAST);
                  addr_data   <= addr_data - 1'b1;
                  addr_factor <= addr_factor + L_STEP;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_interp_seq_ctrl.sv
// Bench for interp_seq_ctrl: default L=4/K=25 instance plus an L=1/K=1 corner
// instance, checked cycle by cycle against an arithmetic tap model.
module tb_interp_seq_ctrl;
   localparam int L = 4;
   localparam int K = 25;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0, failures = 0, cyc = 0, wr_exp = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic       rst, in_valid, in_ready, hist_we, mac_en, tap_first, tap_last, frame_done, init_done;
   logic [7:0] in_data, hist_waddr, hist_wdata, addr_data, addr_factor;
   logic [1:0] phase_idx;

   interp_seq_ctrl dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .hist_we(hist_we), .hist_waddr(hist_waddr), .hist_wdata(hist_wdata),
      .addr_data(addr_data), .addr_factor(addr_factor), .mac_en(mac_en),
      .tap_first(tap_first), .tap_last(tap_last), .phase_idx(phase_idx),
      .frame_done(frame_done), .init_done(init_done)
   );

   logic       rst2, in_valid2, in_ready2, hist_we2, mac_en2, tap_first2, tap_last2, frame_done2, init_done2;
   logic [7:0] in_data2, hist_wdata2;
   logic [3:0] hist_waddr2, addr_data2;
   logic [1:0] addr_factor2;
   logic [0:0] phase_idx2;

   interp_seq_ctrl #(.DATA_W(8), .ADDR_W(4), .COEF_AW(2), .L(1), .K(1), .PH_W(1)) dut2 (
      .clk(clk), .rst(rst2), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
      .hist_we(hist_we2), .hist_waddr(hist_waddr2), .hist_wdata(hist_wdata2),
      .addr_data(addr_data2), .addr_factor(addr_factor2), .mac_en(mac_en2),
      .tap_first(tap_first2), .tap_last(tap_last2), .phase_idx(phase_idx2),
      .frame_done(frame_done2), .init_done(init_done2)
   );

   // 256 back-to-back zero writes at 0..255, then idle with init_done
   task automatic check_clear(input string tag);
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         checks++;
         if ({hist_we, hist_waddr, hist_wdata, init_done, in_ready, mac_en, frame_done} !==
             {1'b1, 8'(i), 8'h00, 4'b0000}) begin
            failures++;
            $display("FAIL %s clear[%0d]: got we=%b wa=%h wd=%h init=%b rdy=%b mac=%b fd=%b, want we=1 wa=%h wd=00 others 0",
                     tag, i, hist_we, hist_waddr, hist_wdata, init_done, in_ready, mac_en, frame_done, 8'(i));
         end
      end
      @(negedge clk);
      checks++;
      if ({hist_we, init_done, in_ready, mac_en, frame_done} !== 5'b01100) begin
         failures++;
         $display("FAIL %s clear_end: got we/init/rdy/mac/fd=%b want 01100", tag,
                  {hist_we, init_done, in_ready, mac_en, frame_done});
      end
      in_valid = 1'b0;
   endtask

   // One complete frame starting from an IDLE negedge; acc = accept cycle
   task automatic run_frame(input logic [7:0] d, input bit hold, input string tag, output int acc);
      logic [7:0] ea;
      int p, k;
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clk);
      acc = cyc;
      checks++;
      if ({hist_we, hist_waddr, hist_wdata, mac_en, in_ready} !== {1'b1, 8'(wr_exp), d, 2'b00}) begin
         failures++;
         $display("FAIL %s write: got we=%b wa=%h wd=%h mac=%b rdy=%b want we=1 wa=%h wd=%h mac=0 rdy=0",
                  tag, hist_we, hist_waddr, hist_wdata, mac_en, in_ready, 8'(wr_exp), d);
      end
      if (!hold) in_valid = 1'b0;
      for (int i = 0; i < L * K; i++) begin
         p  = i / K;
         k  = i % K;
         ea = 8'((wr_exp - k) & 255);
         @(negedge clk);
         checks++;
         if ({mac_en, tap_first, tap_last, phase_idx, addr_data, addr_factor, hist_we, frame_done, in_ready} !==
             {1'b1, k == 0, k == K - 1, 2'(p), ea, 8'(k * L + p), 3'b000}) begin
            failures++;
            $display("FAIL %s tap p=%0d k=%0d: got mac=%b tf=%b tl=%b ph=%0d ad=%h af=%h we=%b fd=%b rdy=%b want ad=%h af=%h tf=%b tl=%b",
                     tag, p, k, mac_en, tap_first, tap_last, phase_idx, addr_data, addr_factor,
                     hist_we, frame_done, in_ready, ea, 8'(k * L + p), k == 0, k == K - 1);
         end
      end
      @(negedge clk);
      checks++;
      if ({frame_done, in_ready, mac_en, hist_we} !== 4'b1100) begin
         failures++;
         $display("FAIL %s done: got fd/rdy/mac/we=%b want 1100", tag, {frame_done, in_ready, mac_en, hist_we});
      end
      wr_exp = (wr_exp + 1) % 256;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; in_data = 8'($urandom);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if ({hist_we, mac_en, tap_first, tap_last, frame_done, init_done, in_ready,
              addr_data, addr_factor, phase_idx, hist_waddr, hist_wdata} !== '0) begin
            failures++;
            $display("FAIL reset_state: got we=%b mac=%b init=%b rdy=%b ad=%h af=%h wa=%h wd=%h want all 0",
                     hist_we, mac_en, init_done, in_ready, addr_data, addr_factor, hist_waddr, hist_wdata);
         end
      end
      rst = 1'b0;
      check_clear("reset");   // in_valid stays high through CLR
      wr_exp = 0;
   endtask

   task automatic test_single();
      int acc;
      run_frame(8'h5A, 1'b0, "single", acc);
   endtask

   task automatic test_wrap();
      int acc, gap;
      for (int n = 0; n < 256; n++) begin
         gap = int'($urandom_range(0, 2));
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            checks++;
            if ({hist_we, mac_en, frame_done, in_ready} !== 4'b0001) begin
               failures++;
               $display("FAIL wrap_idle: got we/mac/fd/rdy=%b want 0001", {hist_we, mac_en, frame_done, in_ready});
            end
         end
         run_frame(8'($urandom), 1'b0, "wrap", acc);
      end
   endtask

   task automatic test_back_to_back();
      int acc, prev;
      prev = -1;
      for (int n = 0; n < 4; n++) begin
         run_frame(8'($urandom), 1'b1, "b2b", acc);
         if (prev >= 0) begin
            checks++;
            if (acc - prev != L * K + 2) begin
               failures++;
               $display("FAIL b2b_period: got %0d want %0d", acc - prev, L * K + 2);
            end
         end
         prev = acc;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset_mid_mac();
      in_valid = 1'b1; in_data = 8'($urandom);
      @(negedge clk);           // WRITE
      for (int i = 0; i <= 40; i++) @(negedge clk);   // now showing tap 40
      checks++;
      if ({mac_en, addr_data} !== {1'b1, 8'((wr_exp - 15) & 255)}) begin
         failures++;
         $display("FAIL midmac_tap40: got mac=%b ad=%h want mac=1 ad=%h", mac_en, addr_data, 8'((wr_exp - 15) & 255));
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({hist_we, mac_en, tap_first, tap_last, frame_done, init_done, in_ready,
           addr_data, addr_factor, phase_idx, hist_waddr, hist_wdata} !== '0) begin
         failures++;
         $display("FAIL midmac_reset: got we=%b mac=%b fd=%b init=%b rdy=%b ad=%h af=%h want all 0",
                  hist_we, mac_en, frame_done, init_done, in_ready, addr_data, addr_factor);
      end
      rst = 1'b0;
      check_clear("midmac");
      wr_exp = 0;
      test_single();
   endtask

   task automatic test_l1k1();
      logic [7:0] d;
      @(negedge clk);
      rst2 = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         checks++;
         if ({hist_we2, hist_waddr2, hist_wdata2, init_done2} !== {1'b1, 4'(i), 8'h00, 1'b0}) begin
            failures++;
            $display("FAIL l1k1_clear[%0d]: got we=%b wa=%h wd=%h init=%b", i, hist_we2, hist_waddr2, hist_wdata2, init_done2);
         end
      end
      @(negedge clk);
      checks++;
      if ({init_done2, in_ready2, hist_we2} !== 3'b110) begin
         failures++;
         $display("FAIL l1k1_init: got init/rdy/we=%b want 110", {init_done2, in_ready2, hist_we2});
      end
      in_valid2 = 1'b1;
      for (int f = 0; f < 6; f++) begin
         d = 8'($urandom);
         in_data2 = d;
         @(negedge clk);
         checks++;
         if ({hist_we2, hist_waddr2, hist_wdata2, mac_en2, in_ready2} !== {1'b1, 4'(f), d, 2'b00}) begin
            failures++;
            $display("FAIL l1k1_write[%0d]: got we=%b wa=%h wd=%h want wa=%h wd=%h", f, hist_we2, hist_waddr2, hist_wdata2, 4'(f), d);
         end
         @(negedge clk);
         checks++;
         if ({mac_en2, tap_first2, tap_last2, addr_data2, addr_factor2, phase_idx2, hist_we2} !==
             {3'b111, 4'(f), 2'b00, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL l1k1_tap[%0d]: got mac=%b tf=%b tl=%b ad=%h af=%h want 1 1 1 ad=%h af=0",
                     f, mac_en2, tap_first2, tap_last2, addr_data2, addr_factor2, 4'(f));
         end
         @(negedge clk);
         checks++;
         if ({frame_done2, in_ready2, mac_en2} !== 3'b110) begin
            failures++;
            $display("FAIL l1k1_done[%0d]: got fd/rdy/mac=%b want 110", f, {frame_done2, in_ready2, mac_en2});
         end
      end
      in_valid2 = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0;
      rst2 = 1'b1; in_valid2 = 1'b0; in_data2 = '0;
      test_reset();
      test_single();
      test_wrap();
      test_back_to_back();
      test_reset_mid_mac();
      test_l1k1();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
